// File: rtl/addr_ram_1w_nr.sv
// One-write, N-read synchronous RAM with per-entry valid bits, granule write masks and flush.
// Define RAM_WRITE_BYPASS_EN to forward a same-cycle write to colliding reads.
module addr_ram_1w_nr #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 10,
  parameter int NREAD  = 2,
  parameter int MASK_W = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   W_en,
  input  logic [AW-1:0]          W_addr,
  input  logic [WIDTH-1:0]       W_data,
  input  logic [MASK_W-1:0]      W_mask,
  input  logic                   flush,
  input  logic [NREAD-1:0]       R_en,
  input  logic [NREAD*AW-1:0]    R_addr,
  output logic [NREAD*WIDTH-1:0] R_data,
  output logic [NREAD-1:0]       R_valid
);

  localparam int G = WIDTH / MASK_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] merged_word;

  // The word a write leaves behind: new data in masked granules, old contents elsewhere.
  always_comb begin
    merged_word = mem[W_addr];
    for (int g = 0; g < MASK_W; g++) begin
      if (W_mask[g]) begin
        merged_word[g*G +: G] = W_data[g*G +: G];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (W_en) begin
      mem[W_addr] <= merged_word;
    end
  end

  // A write in the flush cycle survives: its set lands after the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end
      if (W_en) begin
        valid_q[W_addr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0]    ra;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_word;
    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;

    assign ra = R_addr[p*AW +: AW];

    // Reads see the post-flush valid state; invalid entries return zero data.
    always_comb begin
      rd_valid = valid_q[ra] & ~flush;
      rd_word  = rd_valid ? mem[ra] : '0;
`ifdef RAM_WRITE_BYPASS_EN
      if (W_en && (ra == W_addr)) begin
        rd_valid = 1'b1;
        rd_word  = merged_word;
      end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else if (R_en[p]) begin
        rvalid_q <= rd_valid;
        rdata_q  <= rd_word;
      end
    end

    assign R_data[p*WIDTH +: WIDTH] = rdata_q;
    assign R_valid[p]               = rvalid_q;
  end

endmodule
